// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: aligns stores, issues one word-aligned bus request per operation
// and sign/zero-extends the returned load data for write-back.
module lsu_ctrl #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_ren,
   input  logic              in_wen,
   input  logic [2:0]        in_rd_ctrl,
   input  logic [7:0]        in_wr_ctrl,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_wen,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   output logic [3:0]        req_wstrb,
   input  logic              resp_valid,
   input  logic [DATA_W-1:0] resp_rdata,
   output logic              resp_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic              req_wen_q, req_wen_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic [3:0]        req_wstrb_q, req_wstrb_d;
   logic [DATA_W-1:0] out_rdata_q, out_rdata_d;
   logic              out_err_q, out_err_d;
   logic [2:0]        rd_ctrl_q, rd_ctrl_d;
   logic [1:0]        off_q, off_d;

   logic              misal;
   logic              bad_ctrl;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] ext;

   // Only meaningful when exactly one of in_ren / in_wen is set.
   always_comb begin
      if (in_ren) begin
         misal    = ((in_rd_ctrl == 3'd3 || in_rd_ctrl == 3'd4) && in_addr[0]) ||
                    (in_rd_ctrl == 3'd5 && in_addr[1:0] != 2'b00);
         bad_ctrl = (in_rd_ctrl == 3'd0) || (in_rd_ctrl > 3'd5);
      end else begin
         misal    = (in_wr_ctrl == 8'h03 && in_addr[0]) ||
                    (in_wr_ctrl == 8'h0F && in_addr[1:0] != 2'b00);
         bad_ctrl = !(in_wr_ctrl == 8'h01 || in_wr_ctrl == 8'h03 || in_wr_ctrl == 8'h0F);
      end
   end

   always_comb begin
      shifted = resp_rdata >> {off_q, 3'b000};
      case (rd_ctrl_q)
         3'd1:    ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         3'd2:    ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         3'd3:    ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         3'd4:    ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         3'd5:    ext = shifted;
         default: ext = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_wen_d   = req_wen_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;
      out_rdata_d = out_rdata_q;
      out_err_d   = out_err_q;
      rd_ctrl_d   = rd_ctrl_q;
      off_d       = off_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               rd_ctrl_d   = in_rd_ctrl;
               off_d       = in_addr[1:0];
               out_rdata_d = '0;
               out_err_d   = 1'b0;
               state_d     = StDone;
               if (in_ren && in_wen) begin
                  out_err_d = 1'b1;
               end else if (!in_ren && !in_wen) begin
                  out_err_d = 1'b0;
               end else if (misal || bad_ctrl) begin
                  out_err_d = 1'b1;
               end else begin
                  state_d     = StReq;
                  req_wen_d   = in_wen;
                  req_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                  req_wdata_d = in_wen ? (in_wdata << {in_addr[1:0], 3'b000}) : '0;
                  req_wstrb_d = in_wen ? (in_wr_ctrl[3:0] << in_addr[1:0]) : 4'b0000;
               end
            end
         end
         StReq: begin
            if (req_ready) state_d = StWait;
         end
         StWait: begin
            if (resp_valid) begin
               out_rdata_d = req_wen_q ? '0 : ext;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         req_wen_q   <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wstrb_q <= 4'b0000;
         out_rdata_q <= '0;
         out_err_q   <= 1'b0;
         rd_ctrl_q   <= 3'd0;
         off_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         req_wen_q   <= req_wen_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
         out_rdata_q <= out_rdata_d;
         out_err_q   <= out_err_d;
         rd_ctrl_q   <= rd_ctrl_d;
         off_q       <= off_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign req_valid  = (state_q == StReq);
   assign resp_ready = (state_q == StWait);
   assign out_valid  = (state_q == StDone);
   assign req_wen    = req_wen_q;
   assign req_addr   = req_addr_q;
   assign req_wdata  = req_wdata_q;
   assign req_wstrb  = req_wstrb_q;
   assign out_rdata  = out_rdata_q;
   assign out_err    = out_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a byte-level reference model predicts each operation's bus
// request, result, error flag and latency while a bus model applies random stalls.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_ren, in_wen;
   logic [2:0]  in_rd_ctrl;
   logic [7:0]  in_wr_ctrl;
   logic [31:0] in_addr, in_wdata;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic        out_valid, out_ready, out_err;
   logic [31:0] out_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ren     (in_ren),
      .in_wen     (in_wen),
      .in_rd_ctrl (in_rd_ctrl),
      .in_wr_ctrl (in_wr_ctrl),
      .in_addr    (in_addr),
      .in_wdata   (in_wdata),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_ready (resp_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rdata  (out_rdata),
      .out_err    (out_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: works in bytes and access sizes rather than shifts.
   task automatic model_op(input logic ren, input logic wen, input logic [2:0] rdc,
                           input logic [7:0] wrc, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           output bit bus, output bit err, output logic [31:0] e_addr,
                           output logic [31:0] e_wdata, output logic [3:0] e_wstrb,
                           output logic [31:0] e_rdata);
      int     off;
      int     size;
      bit     sgn;
      longint v;
      off     = int'(addr % 4);
      size    = 0;
      sgn     = 1'b0;
      bus     = 1'b0;
      err     = 1'b0;
      e_addr  = addr - addr % 4;
      e_wdata = '0;
      e_wstrb = '0;
      e_rdata = '0;
      if (ren && wen) begin
         err = 1'b1;
      end else if (ren) begin
         case (rdc)
            3'd1: begin size = 1; sgn = 1'b1; end
            3'd2: size = 1;
            3'd3: begin size = 2; sgn = 1'b1; end
            3'd4: size = 2;
            3'd5: size = 4;
            default: size = 0;
         endcase
         if (size == 0 || off % size != 0) err = 1'b1;
         else bus = 1'b1;
         if (bus) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(rdata[8*(off+i) +: 8]) << (8 * i);
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
            e_rdata = v[31:0];
         end
      end else if (wen) begin
         case (wrc)
            8'h01:   size = 1;
            8'h03:   size = 2;
            8'h0F:   size = 4;
            default: size = 0;
         endcase
         if (size == 0 || off % size != 0) err = 1'b1;
         else bus = 1'b1;
         if (bus) begin
            for (int i = 0; i < 4; i++) begin
               if (i + off < 4) begin
                  e_wdata[8*(i+off) +: 8] = wdata[8*i +: 8];
                  if (i < size) e_wstrb[i+off] = 1'b1;
               end
            end
         end
      end
   endtask

   // Called just after a falling edge with the unit idle.
   task automatic run_op(input logic ren, input logic wen, input logic [2:0] rdc,
                         input logic [7:0] wrc, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int rq_lat, input int rs_lat,
                         input int o_lat);
      bit          bus, err, done, seen_out;
      logic [31:0] e_addr, e_wdata, e_rdata;
      logic [3:0]  e_wstrb;
      int          cyc, rq_cnt, rs_cnt, o_cnt, req_cycles, exp_lat;
      model_op(ren, wen, rdc, wrc, addr, wdata, rdata, bus, err, e_addr, e_wdata, e_wstrb, e_rdata);
      exp_lat    = bus ? 3 + rq_lat + rs_lat : 1;
      rq_cnt     = rq_lat;
      rs_cnt     = rs_lat;
      o_cnt      = o_lat;
      req_cycles = 0;
      done       = 1'b0;
      seen_out   = 1'b0;
      in_valid   = 1'b1;
      in_ren     = ren;
      in_wen     = wen;
      in_rd_ctrl = rdc;
      in_wr_ctrl = wrc;
      in_addr    = addr;
      in_wdata   = wdata;
      check_val("in_ready_idle", 32'(in_ready), 32'd1);
      @(negedge clk);
      // Scramble the operation fields; the unit must have captured them already.
      in_valid   = 1'b0;
      in_ren     = 1'($urandom);
      in_wen     = 1'($urandom);
      in_rd_ctrl = 3'($urandom);
      in_wr_ctrl = 8'($urandom);
      in_addr    = $urandom;
      in_wdata   = $urandom;
      cyc        = 1;
      while (!done && cyc < 200) begin
         check_val("in_ready_busy", 32'(in_ready), 32'd0);
         req_ready = 1'($urandom);
         if (req_valid) begin
            req_cycles++;
            check_val("req_wen", 32'(req_wen), 32'(wen));
            check_val("req_addr", req_addr, e_addr);
            check_val("req_wstrb", 32'(req_wstrb), 32'(e_wstrb));
            if (wen) check_val("req_wdata", req_wdata, e_wdata);
            if (rq_cnt > 0) begin
               req_ready = 1'b0;
               rq_cnt--;
            end else begin
               req_ready = 1'b1;
            end
         end
         if (resp_ready) begin
            if (rs_cnt > 0) begin
               resp_valid = 1'b0;
               resp_rdata = $urandom;
               rs_cnt--;
            end else begin
               resp_valid = 1'b1;
               resp_rdata = rdata;
            end
         end else begin
            resp_valid = 1'($urandom);
            resp_rdata = $urandom;
         end
         if (out_valid) begin
            if (!seen_out) check_val("latency", 32'(cyc), 32'(exp_lat));
            seen_out = 1'b1;
            check_val("out_rdata", out_rdata, (bus && ren) ? e_rdata : 32'd0);
            check_val("out_err", 32'(out_err), 32'(err));
            if (o_cnt > 0) begin
               out_ready = 1'b0;
               o_cnt--;
            end else begin
               out_ready = 1'b1;
               done      = 1'b1;
            end
         end else begin
            out_ready = 1'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      out_ready  = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      check_val("op_completed", 32'(done), 32'd1);
      check_val("req_valid_cycles", 32'(req_cycles), bus ? 32'(rq_lat + 1) : 32'd0);
      check_val("idle_out_valid", 32'(out_valid), 32'd0);
      check_val("idle_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_state();
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_req_valid", 32'(req_valid), 32'd0);
      check_val("rst_resp_ready", 32'(resp_ready), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_err", 32'(out_err), 32'd0);
      check_val("rst_req_wen", 32'(req_wen), 32'd0);
      check_val("rst_req_addr", req_addr, 32'd0);
      check_val("rst_req_wdata", req_wdata, 32'd0);
      check_val("rst_req_wstrb", 32'(req_wstrb), 32'd0);
      check_val("rst_out_rdata", out_rdata, 32'd0);
   endtask

   initial begin
      logic       ren, wen;
      logic [7:0] wrc;
      int         sel;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_ren     = 1'b0;
      in_wen     = 1'b0;
      in_rd_ctrl = 3'd0;
      in_wr_ctrl = 8'h00;
      in_addr    = '0;
      in_wdata   = '0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      @(negedge clk);

      // Directed cases from the plan.
      run_op(1'b1, 1'b0, 3'd1, 8'h00, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'd4, 8'h00, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'd3, 8'h00, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 0, 0);
      run_op(1'b0, 1'b1, 3'd0, 8'h01, 32'h8000_0001, 32'h0000_00AB, 32'h1357_9BDF, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'd5, 8'h00, 32'h8000_0002, 32'h0, 32'h1111_2222, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'd5, 8'h00, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 3, 2, 2);
      run_op(1'b0, 1'b1, 3'd0, 8'h03, 32'h8000_0022, 32'h1234_5678, 32'h0, 3, 2, 2);

      for (int n = 0; n < 200; n++) begin
         sel = int'($urandom_range(0, 7));
         ren = (sel == 1) || (sel >= 2 && sel <= 4);
         wen = (sel == 1) || (sel >= 5);
         case ($urandom_range(0, 4))
            0:       wrc = 8'h01;
            1:       wrc = 8'h03;
            2:       wrc = 8'h0F;
            3:       wrc = 8'h0F;
            default: wrc = 8'($urandom);
         endcase
         run_op(ren, wen, 3'($urandom), wrc, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)));
      end

      // Asynchronous reset while waiting for the bus response.
      in_valid   = 1'b1;
      in_ren     = 1'b1;
      in_wen     = 1'b0;
      in_rd_ctrl = 3'd5;
      in_addr    = 32'h8000_0008;
      @(negedge clk);
      in_valid  = 1'b0;
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check_val("wait_resp_ready", 32'(resp_ready), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_state();
      @(negedge clk);
      rst        = 1'b0;
      resp_valid = 1'b1;
      resp_rdata = 32'hDEAD_BEEF;
      repeat (2) begin
         @(negedge clk);
         check_val("late_resp_out_valid", 32'(out_valid), 32'd0);
         check_val("late_resp_in_ready", 32'(in_ready), 32'd1);
      end
      resp_valid = 1'b0;
      run_op(1'b1, 1'b0, 3'd5, 8'h00, 32'h8000_0004, 32'h0, 32'h0BAD_CAFE, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store unit between the execute stage and a variable-latency, word-wide data-memory bus. Replaces the zero-latency DPI memory access path.
- Accepts one memory operation per handshake, aligns store data and byte strobes, and issues a word-aligned bus request.
- Waits for the bus response, then sign/zero-extends load data for write-back.
- Flags misaligned accesses without touching the bus.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operation offered by execute stage
- in_ready  out  1  unit can accept an operation
- in_ren  in  1  load
- in_wen  in  1  store
- in_rd_ctrl  in  3  load type: 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw
- in_wr_ctrl  in  8  unshifted store mask: 8'h01 sb, 8'h03 sh, 8'h0F sw
- in_addr  in  ADDR_W  byte address
- in_wdata  in  DATA_W  store data, right-justified
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_wen  out  1  1 = write
- req_addr  out  ADDR_W  word-aligned address, in_addr with [1:0] = 0
- req_wdata  out  DATA_W  shifted store data
- req_wstrb  out  4  shifted byte strobes; 0 for reads
- resp_valid  in  1  bus response (read data or write ack)
- resp_rdata  in  DATA_W  read word
- resp_ready  out  1  unit accepts response
- out_valid  out  1  result valid
- out_ready  in  1  write-back accepts result
- out_rdata  out  DATA_W  extended load data; 0 for stores, errors and no-ops
- out_err  out  1  misaligned access or illegal control

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (asynchronous, any state):
  - state returns to IDLE.
  - req_valid, resp_ready, out_valid, out_err are 0.
  - req_addr, req_wdata, req_wstrb, req_wen, out_rdata are 0.
  - An in-flight bus transaction is abandoned; the bus shares rst.
- Input handshake:
  - in_ready = 1 only in IDLE.
  - The operation is accepted on the clock edge with in_valid && in_ready.
  - All operation fields are registered at acceptance; inputs are not used after that edge.
- Decode at acceptance, first matching rule wins:
  - in_ren && in_wen → DONE, out_err = 1.
  - Neither in_ren nor in_wen → DONE, out_err = 0, out_rdata = 0.
  - Misaligned (lh/lhu/sh with addr[0] = 1; lw/sw with addr[1:0] != 0) → DONE, out_err = 1, no bus request.
  - Undefined in_rd_ctrl on a load, or undefined in_wr_ctrl on a store → DONE, out_err = 1.
  - Otherwise → REQ.
- Store alignment: req_wdata = in_wdata << (8 × addr[1:0]); req_wstrb = in_wr_ctrl[3:0] << addr[1:0], truncated to 4 bits.
- REQ:
  - req_valid = 1; all req_* fields stay stable until req_ready.
  - On req_valid && req_ready → WAIT. Earliest bus-accept edge is one cycle after acceptance.
- WAIT:
  - resp_ready = 1.
  - On resp_valid → DONE.
  - Load: out_rdata is registered as resp_rdata >> (8 × addr[1:0]), then extended per in_rd_ctrl (sign for lb/lh, zero for lbu/lhu).
  - Store: out_rdata = 0.
  - resp_valid outside WAIT is ignored; resp_ready is 0 outside WAIT.
- DONE:
  - out_valid = 1; out_rdata and out_err held stable.
  - On out_ready → IDLE. The next acceptance is possible in the following cycle.
- Latency:
  - Minimum load/store, accept to out_valid: 3 cycles (bus ready and response each in the first cycle offered).
  - Error or no-op: out_valid in the cycle after acceptance.
- Throughput: one operation in flight; no pipelining.

Test Plan:
- lb at 0x80000003, resp_rdata 0x80FF1234 → req_addr 0x80000000, req_wstrb 0, out_rdata 0xFFFFFF80, out_err 0.
- lhu at 0x80000002, resp_rdata 0xBEEF1234 → out_rdata 0x0000BEEF. The same access as lh → 0xFFFFBEEF.
- sb, in_wdata 0x000000AB at 0x80000001 → req_wen 1, req_addr 0x80000000, req_wdata 0x0000AB00, req_wstrb 4'b0010; after resp_valid, out_valid with out_rdata 0.
- lw at 0x80000002 → req_valid never asserted; out_valid and out_err = 1 one cycle after acceptance; IDLE after out_ready.
- req_ready low for 3 cycles, then resp_valid delayed 2 cycles, then out_ready low for 2 cycles → req_* stable while stalled, in_ready 0 throughout, out_rdata stable; exactly one request issued.
- rst asserted while in WAIT → same-cycle (asynchronous) return to IDLE with all outputs 0; a late resp_valid is ignored; a following lw at 0x80000004 completes normally.
